note_glyph_writer: RTL
======================

# note_glyph_writer

Downstream consumer of the note-to-character lookup. Accepts one 6-bit note code per transaction and resolves it to three glyph base addresses in the font ROM (letter, accidental, octave number). It then fetches the 8 rows of each glyph from a synchronous font ROM and writes the 24 glyph-row bytes into a fixed 3-character field of the display frame buffer. It sits between the note sequencer, which supplies notes, and the frame buffer, which the display scanner reads.

## Interface
- FB_ADDR_W, 10: frame-buffer write address width.
- SLOT_BASE, 0: frame-buffer address of row 0 of character 0. SLOT_BASE+23 must fit in FB_ADDR_W bits.
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  reset: one clock domain, asynchronous assert, active-low.
- note_in  in  6  note code. 0 = rest; 1..63 = A1..B6 in semitone order.
- note_valid  in  1  note_in is valid this cycle.
- note_ready  out  1  block can accept a note (high only in IDLE).
- rom_addr  out  9  font ROM byte address. Registered.
- rom_data  in  8  font ROM data. Valid on the cycle after rom_addr is sampled (1-cycle latency).
- fb_wr_en  out  1  frame-buffer write request.
- fb_wr_addr  out  FB_ADDR_W  frame-buffer write address.
- fb_wr_data  out  8  glyph row byte.
- fb_wr_ready  in  1  frame buffer accepts the write this cycle.
- busy  out  1  transaction in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when the last write has completed.

## Operation
- Acceptance: note_valid && note_ready at a rising edge.
  - Latch note_in into note_q. note_in is ignored for the remainder of the transaction.
  - Clear char index c (0..2) and row index r (0..7).
- Glyph bases come from note_q via the lookup sub-module: c=0 letter, c=1 symbol (space or hash), c=2 number.
- Rest (note 0) yields three spaces (0x100) and is written like any other note.
- Glyph base addresses are multiples of 8, so rom_addr = base[8:3] concatenated with r.
- States:
  - IDLE: note_ready=1. On acceptance go to FETCH.
  - FETCH: drive rom_addr = base(c)|r. Go to CAPTURE.
  - CAPTURE: register rom_data into fb_wr_data. Set fb_wr_addr = SLOT_BASE + 8*c + r. Go to WRITE.
  - WRITE: fb_wr_en=1. Hold until fb_wr_ready=1.
    - On the ready edge: if r<7, increment r and go to FETCH.
    - Else if c<2, increment c, clear r, and go to FETCH.
    - Else go to DONE.
  - DONE: done=1 for one cycle. Go to IDLE.
- Backpressure: while fb_wr_en=1 and fb_wr_ready=0, fb_wr_addr and fb_wr_data hold stable. Exactly one write per glyph row; no write is dropped or duplicated.
- The lookup's out-of-range default (0x0C0) is unreachable for 6-bit codes. It needs no special handling.
- note_valid during busy: not accepted and not queued. The sequencer must hold note_valid until note_ready.
- Reset mid-transaction: immediate return to IDLE. No further writes; frame-buffer rows already written are left as is.

## Timing
- Reset values:
  - note_ready=1 (IDLE)
  - busy=0, done=0, fb_wr_en=0
  - rom_addr=0, fb_wr_addr=0, fb_wr_data=0
  - note_q=0, c=0, r=0
- With acceptance at edge E0 and fb_wr_ready tied high:
  - Row 0 of char 0: FETCH in cycle 1, CAPTURE in cycle 2, fb_wr_en high in cycle 3.
  - Each row takes 3 cycles; 24 rows take 72 cycles.
  - done is high in cycle 73. note_ready is high in cycle 74, so back-to-back acceptance is possible at E74.
- Each cycle fb_wr_ready is low during WRITE adds exactly one cycle to the transaction.
- All outputs are registered or decoded from the state register only. No combinational path from the inputs.

## Structure
- Shared package note_display_pkg:
  - state enum: IDLE, FETCH, CAPTURE, WRITE, DONE
  - NUM_CHARS=3, GLYPH_ROWS=8
  - font address constants (NUMBER_1..6, LETTER_A..G, SYMBOL_SPACE, SYMBOL_HASH, INVALID); the lookup block uses the same package
- Sub-module: one instance of note_rom, driven by note_q. Its three address outputs feed a 3:1 mux selected by c.
- Everything else is one sequential always block plus the output decode.

## Test plan
- Reset, then note 2 (A#1), ready tied high:
  - rom_addr sequence 0x008..0x00F, 0x118..0x11F, 0x188..0x18F.
  - 24 writes at SLOT_BASE+0..23 with data matching the ROM model.
  - done in cycle 73.
- Note 0 (rest): all three characters read 0x100..0x107; 24 writes; one done pulse.
- Note 2 with fb_wr_ready low for 5 cycles on row 3 of char 1:
  - fb_wr_addr = SLOT_BASE+11 and its data held stable throughout.
  - No duplicate write; done in cycle 78.
- note_valid held high with changing note_in during busy:
  - note_ready=0 and no re-acceptance.
  - Addresses stay those of the latched note.
- Assert rst_n low after 10 writes:
  - All outputs at reset values immediately; no 11th write.
  - A new note 63 (B6) afterwards gives letter base 0x010, space 0x100, number base 0x1B0, 24 writes.
- Two notes back-to-back (13 then 28): second accepted at E74; its rom_addr starts 0x018 (C) and ends 0x19F (number 3).

Source files
------------

// File: rtl/note_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_display_pkg
//  Description : Shared types and font-ROM glyph base addresses used by the
//                note lookup and the glyph writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package note_display_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int NUM_CHARS  = 3;
    localparam int GLYPH_ROWS = 8;

    // Glyph base addresses: character code * 8, modulo the 512-byte font ROM
    localparam logic [8:0] NUMBER_1     = 9'h188;
    localparam logic [8:0] NUMBER_2     = 9'h190;
    localparam logic [8:0] NUMBER_3     = 9'h198;
    localparam logic [8:0] NUMBER_4     = 9'h1A0;
    localparam logic [8:0] NUMBER_5     = 9'h1A8;
    localparam logic [8:0] NUMBER_6     = 9'h1B0;
    localparam logic [8:0] LETTER_A     = 9'h008;
    localparam logic [8:0] LETTER_B     = 9'h010;
    localparam logic [8:0] LETTER_C     = 9'h018;
    localparam logic [8:0] LETTER_D     = 9'h020;
    localparam logic [8:0] LETTER_E     = 9'h028;
    localparam logic [8:0] LETTER_F     = 9'h030;
    localparam logic [8:0] LETTER_G     = 9'h038;
    localparam logic [8:0] SYMBOL_SPACE = 9'h100;
    localparam logic [8:0] SYMBOL_HASH  = 9'h118;
    localparam logic [8:0] INVALID      = 9'h0C0;

    // Glyph bases are 8-aligned, so OR-ing the row index selects the row byte
    function automatic logic [8:0] glyph_row_addr(input logic [8:0] base,
                                                  input logic [2:0] row);
        return base | {6'd0, row};
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_glyph_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : note_glyph_writer_if
//  Description : Note handshake, font-ROM port and frame-buffer write port of
//                the glyph writer. master = writer side, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface note_glyph_writer_if #(
    parameter int FB_ADDR_W = 10
);
    logic [5:0]           note_in;
    logic                 note_valid;
    logic                 note_ready;
    logic [8:0]           rom_addr;
    logic [7:0]           rom_data;
    logic                 fb_wr_en;
    logic [FB_ADDR_W-1:0] fb_wr_addr;
    logic [7:0]           fb_wr_data;
    logic                 fb_wr_ready;
    logic                 busy;
    logic                 done;

    modport master (
        input  note_in, note_valid, rom_data, fb_wr_ready,
        output note_ready, rom_addr, fb_wr_en, fb_wr_addr, fb_wr_data, busy, done
    );

    modport slave (
        output note_in, note_valid, rom_data, fb_wr_ready,
        input  note_ready, rom_addr, fb_wr_en, fb_wr_addr, fb_wr_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/note_rom.sv
`default_nettype none
// ============================================================================
//  Module      : note_rom
//  Description : Combinational note-to-glyph lookup. Code 0 is a rest (three
//                spaces); codes 1..63 are A1..B6 with the octave digit
//                advancing at every A.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_rom
    import note_display_pkg::*;
(
    input  logic [5:0] note,
    output logic [8:0] letter_addr,
    output logic [8:0] symbol_addr,
    output logic [8:0] number_addr
);

    logic [5:0] w_idx;
    logic [2:0] w_octave;
    logic [5:0] w_semi;

    // Split the code into octave (0..5) and semitone within octave (0 = A)
    always_comb begin
        w_idx = note - 6'd1;
        if (w_idx >= 6'd60)      w_octave = 3'd5;
        else if (w_idx >= 6'd48) w_octave = 3'd4;
        else if (w_idx >= 6'd36) w_octave = 3'd3;
        else if (w_idx >= 6'd24) w_octave = 3'd2;
        else if (w_idx >= 6'd12) w_octave = 3'd1;
        else                     w_octave = 3'd0;
        w_semi = w_idx - ({w_octave, 3'b000} + {1'b0, w_octave, 2'b00});
    end

    // Map semitone/octave to glyph bases; a rest overrides all three
    always_comb begin
        letter_addr = INVALID;
        symbol_addr = SYMBOL_SPACE;
        number_addr = INVALID;
        case (w_semi)
            6'd0, 6'd1:  letter_addr = LETTER_A;
            6'd2:        letter_addr = LETTER_B;
            6'd3, 6'd4:  letter_addr = LETTER_C;
            6'd5, 6'd6:  letter_addr = LETTER_D;
            6'd7:        letter_addr = LETTER_E;
            6'd8, 6'd9:  letter_addr = LETTER_F;
            6'd10, 6'd11: letter_addr = LETTER_G;
            default:     letter_addr = INVALID;
        endcase
        case (w_semi)
            6'd1, 6'd4, 6'd6, 6'd9, 6'd11: symbol_addr = SYMBOL_HASH;
            default:                       symbol_addr = SYMBOL_SPACE;
        endcase
        case (w_octave)
            3'd0:    number_addr = NUMBER_1;
            3'd1:    number_addr = NUMBER_2;
            3'd2:    number_addr = NUMBER_3;
            3'd3:    number_addr = NUMBER_4;
            3'd4:    number_addr = NUMBER_5;
            3'd5:    number_addr = NUMBER_6;
            default: number_addr = INVALID;
        endcase
        if (note == 6'd0) begin
            letter_addr = SYMBOL_SPACE;
            symbol_addr = SYMBOL_SPACE;
            number_addr = SYMBOL_SPACE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_glyph_writer.sv
`default_nettype none
// ============================================================================
//  Module      : note_glyph_writer
//  Description : Resolves a note code to three glyphs, fetches their 8 rows
//                each from a 1-cycle-latency font ROM and writes the 24 row
//                bytes into a fixed 3-character frame-buffer field.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_glyph_writer
    import note_display_pkg::*;
#(
    parameter int                   FB_ADDR_W = 10,
    parameter logic [FB_ADDR_W-1:0] SLOT_BASE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    note_glyph_writer_if.master   bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [5:0]           r_note_q;
    logic [1:0]           r_c;
    logic [2:0]           r_r;
    logic [1:0]           w_c_nxt;
    logic [2:0]           w_r_nxt;
    logic                 w_load_addr;
    logic [8:0]           r_rom_addr;
    logic [FB_ADDR_W-1:0] r_fb_wr_addr;
    logic [7:0]           r_fb_wr_data;
    logic                 w_accept;
    logic [5:0]           w_lookup_note;
    logic [8:0]           w_letter;
    logic [8:0]           w_symbol;
    logic [8:0]           w_number;
    logic [8:0]           w_base;

    assign w_accept = (r_state == IDLE) && bus.note_valid;

    // In IDLE the lookup sees the incoming code so the first fetch address
    // can be registered on the acceptance edge; afterwards only note_q.
    assign w_lookup_note = (r_state == IDLE) ? bus.note_in : r_note_q;

    note_rom u_note_rom (
        .note        (w_lookup_note),
        .letter_addr (w_letter),
        .symbol_addr (w_symbol),
        .number_addr (w_number)
    );

    // Glyph base of the character the next fetch will address
    always_comb begin
        case (w_c_nxt)
            2'd0:    w_base = w_letter;
            2'd1:    w_base = w_symbol;
            default: w_base = w_number;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, next char/row indices and fetch-address load strobe
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_r_nxt     = r_r;
        w_load_addr = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.note_valid) begin
                    w_state_nxt = FETCH;
                    w_c_nxt     = 2'd0;
                    w_r_nxt     = 3'd0;
                    w_load_addr = 1'b1;
                end
            end
            FETCH:   w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = WRITE;
            WRITE: begin
                if (bus.fb_wr_ready) begin
                    if (r_r != 3'(GLYPH_ROWS - 1)) begin
                        w_r_nxt     = r_r + 3'd1;
                        w_state_nxt = FETCH;
                        w_load_addr = 1'b1;
                    end else if (r_c != 2'(NUM_CHARS - 1)) begin
                        w_c_nxt     = r_c + 2'd1;
                        w_r_nxt     = 3'd0;
                        w_state_nxt = FETCH;
                        w_load_addr = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: latched note, indices, ROM address and frame-buffer write word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note_q     <= '0;
            r_c          <= '0;
            r_r          <= '0;
            r_rom_addr   <= '0;
            r_fb_wr_addr <= '0;
            r_fb_wr_data <= '0;
        end else begin
            if (w_accept) begin
                r_note_q <= bus.note_in;
            end
            r_c <= w_c_nxt;
            r_r <= w_r_nxt;
            if (w_load_addr) begin
                r_rom_addr <= glyph_row_addr(w_base, w_r_nxt);
            end
            // Captured once per row, so the word holds through any stall
            if (r_state == CAPTURE) begin
                r_fb_wr_data <= bus.rom_data;
                r_fb_wr_addr <= SLOT_BASE + FB_ADDR_W'({r_c, r_r});
            end
        end
    end

    assign bus.note_ready = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.fb_wr_en   = (r_state == WRITE);
    assign bus.rom_addr   = r_rom_addr;
    assign bus.fb_wr_addr = r_fb_wr_addr;
    assign bus.fb_wr_data = r_fb_wr_data;

endmodule
`default_nettype wire
